// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side bus responder. Answers Enable/RW/Address/WriteData
//               requests with registered read data and a four-phase MFC
//               handshake after WAIT_CYCLES wait states. Includes a preload
//               port for loading program images while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Enable,
  input  logic                 RW,
  input  logic [15:0]          Address,
  input  logic [15:0]          WriteData,
  output logic [15:0]          DataToMDR,
  output logic                 MFC,
  output logic                 addr_err,
  output logic                 busy,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [15:0]          load_data
);

  localparam int         DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0] C_WAIT    = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [15:0]          mem_q [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rw_q, rw_d;
  logic [15:0]          wdata_q, wdata_d;
  logic                 oor_q, oor_d;
  logic [15:0]          dout_q, dout_d;
  logic                 mfc_q, mfc_d;
  logic                 err_q, err_d;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [15:0]          mem_wdata;
  logic                 addr_oor;

  // Any address bit above the array index makes the access out of range.
  assign addr_oor = (Address >> ADDR_BITS) != 16'd0;

  // Next-state logic: request latch, wait countdown, access and handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    oor_d     = oor_q;
    dout_d    = dout_q;
    mfc_d     = mfc_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (Enable) begin
          // Latch the whole request so later bus changes are ignored.
          addr_d  = Address[ADDR_BITS-1:0];
          rw_d    = RW;
          wdata_d = WriteData;
          oor_d   = addr_oor;
          cnt_d   = C_WAIT;
          state_d = S_WAIT;
        end else if (load_en) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr;
          mem_wdata = load_data;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (rw_q) begin
            dout_d = oor_q ? 16'h0000 : mem_q[addr_q];
          end else if (!oor_q) begin
            mem_we = 1'b1;
          end
          mfc_d   = 1'b1;
          err_d   = oor_q;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // ACK holds MFC until Enable is seen low, which already guarantees no
      // new access starts before the controller releases; RELEASE is only a
      // guard encoding and behaves identically.
      S_ACK, S_RELEASE: begin
        if (!Enable) begin
          mfc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= 16'h0000;
      oor_q   <= 1'b0;
      dout_q  <= 16'h0000;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
    end
  end

  // Word array: not cleared by reset, but no write lands on a reset edge.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign DataToMDR = dout_q;
  assign MFC       = mfc_q;
  assign addr_err  = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
